// File: rtl/vga_mem_arbiter_if.sv
// Request, issue and return signals shared by the video fetch path, host port,
// single-port RAM and the arbiter. Suffixes are from the arbiter's point of view.
interface vga_mem_arbiter_if #(
    parameter int AW = 17,
    parameter int DW = 16
);
    logic          blank_i;
    logic          vid_req_i;
    logic [AW-1:0] vid_addr_i;
    logic          vid_ack_o;
    logic          vid_rvalid_o;
    logic [DW-1:0] vid_rdata_o;
    logic          host_valid_i;
    logic          host_we_i;
    logic [AW-1:0] host_addr_i;
    logic [DW-1:0] host_wdata_i;
    logic          host_ready_o;
    logic          host_rvalid_o;
    logic [DW-1:0] host_rdata_o;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;

    modport slave (
        input  blank_i, vid_req_i, vid_addr_i,
        input  host_valid_i, host_we_i, host_addr_i, host_wdata_i,
        input  mem_rdata_i,
        output vid_ack_o, vid_rvalid_o, vid_rdata_o,
        output host_ready_o, host_rvalid_o, host_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output blank_i, vid_req_i, vid_addr_i,
        output host_valid_i, host_we_i, host_addr_i, host_wdata_i,
        output mem_rdata_i,
        input  vid_ack_o, vid_rvalid_o, vid_rdata_o,
        input  host_ready_o, host_rvalid_o, host_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Single-port video RAM arbiter: video wins during active display (with a host
// anti-starvation slot), host wins during blanking; read data routed back by tag.
module vga_mem_arbiter #(
    parameter int AW        = 17,
    parameter int DW        = 16,
    parameter int RD_LAT    = 2,
    parameter int HOST_SLOT = 8
) (
    input logic              clk_i,
    input logic              rst_i,
    vga_mem_arbiter_if.slave bus
);
    localparam int unsigned TAGS = RD_LAT + 1;
    localparam int          SW   = $clog2(HOST_SLOT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(HOST_SLOT - 1);

    typedef enum logic {
        OWN_VID  = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    typedef struct packed {
        logic   rd;
        owner_e owner;
    } tag_t;

    logic          host_gnt;
    logic          vid_gnt;
    logic [SW-1:0] starve_q, starve_d;
    tag_t          tag_d;
    tag_t          tag_q [TAGS];

    logic          mem_en_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          vid_rvalid_q, host_rvalid_q;
    logic [DW-1:0] vid_rdata_q, host_rdata_q;

    always_comb begin
        host_gnt = bus.host_valid_i &&
                   (!bus.vid_req_i || bus.blank_i || starve_q == STARVE_MAX);
        vid_gnt  = bus.vid_req_i && !host_gnt;

        starve_d = '0;
        if (bus.host_valid_i && !host_gnt)
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;

        tag_d.rd    = vid_gnt || (host_gnt && !bus.host_we_i);
        tag_d.owner = host_gnt ? OWN_HOST : OWN_VID;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q      <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            vid_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            vid_rdata_q   <= '0;
            host_rdata_q  <= '0;
            for (int unsigned i = 0; i < TAGS; i++)
                tag_q[i] <= '0;
        end else begin
            starve_q <= starve_d;
            mem_en_q <= vid_gnt || host_gnt;
            mem_we_q <= host_gnt && bus.host_we_i;
            if (vid_gnt)
                mem_addr_q <= bus.vid_addr_i;
            else if (host_gnt)
                mem_addr_q <= bus.host_addr_i;
            if (host_gnt && bus.host_we_i)
                mem_wdata_q <= bus.host_wdata_i;

            // Stage k describes the access issued k cycles ago; the last stage
            // lines up with the cycle its read data is on mem_rdata_i.
            tag_q[0] <= tag_d;
            for (int unsigned i = 1; i < TAGS; i++)
                tag_q[i] <= tag_q[i-1];

            vid_rvalid_q  <= tag_q[TAGS-1].rd && tag_q[TAGS-1].owner == OWN_VID;
            host_rvalid_q <= tag_q[TAGS-1].rd && tag_q[TAGS-1].owner == OWN_HOST;
            if (tag_q[TAGS-1].rd && tag_q[TAGS-1].owner == OWN_VID)
                vid_rdata_q <= bus.mem_rdata_i;
            if (tag_q[TAGS-1].rd && tag_q[TAGS-1].owner == OWN_HOST)
                host_rdata_q <= bus.mem_rdata_i;
        end
    end

    assign bus.vid_ack_o     = vid_gnt;
    assign bus.host_ready_o  = host_gnt;
    assign bus.mem_en_o      = mem_en_q;
    assign bus.mem_we_o      = mem_we_q;
    assign bus.mem_addr_o    = mem_addr_q;
    assign bus.mem_wdata_o   = mem_wdata_q;
    assign bus.vid_rvalid_o  = vid_rvalid_q;
    assign bus.vid_rdata_o   = vid_rdata_q;
    assign bus.host_rvalid_o = host_rvalid_q;
    assign bus.host_rdata_o  = host_rdata_q;
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model with a behavioural RAM.
module tb_vga_mem_arbiter;
    localparam int AW        = 17;
    localparam int DW        = 16;
    localparam int RD_LAT    = 2;
    localparam int HOST_SLOT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    vga_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    vga_mem_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .HOST_SLOT(HOST_SLOT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        if (a == 17'h00010) return 16'hABCD;
        return (a[DW-1:0] * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Behavioural RAM: data for a read strobe appears RD_LAT cycles later.
    logic [DW-1:0] ram [logic [AW-1:0]];
    logic [DW-1:0] rd_pipe [RD_LAT];

    function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
        return ram.exists(a) ? ram[a] : init_word(a);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en_o && bus.mem_we_o) ram[bus.mem_addr_o] = bus.mem_wdata_o;
        rd_pipe[0] <= (bus.mem_en_o && !bus.mem_we_o) ? ram_rd(bus.mem_addr_o) : '0;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata_i = rd_pipe[RD_LAT-1];

    // Reference model state
    typedef struct {
        int            due;
        bit            host;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          exp_q[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int            losses = 0;
    int            cyc = 0;
    int            vid_seen = 0;
    logic          exp_en = 1'b0, exp_we = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_mem_en",      32'(bus.mem_en_o),      0);
        check("rst_mem_we",      32'(bus.mem_we_o),      0);
        check("rst_mem_addr",    32'(bus.mem_addr_o),    0);
        check("rst_mem_wdata",   32'(bus.mem_wdata_o),   0);
        check("rst_vid_rvalid",  32'(bus.vid_rvalid_o),  0);
        check("rst_host_rvalid", 32'(bus.host_rvalid_o), 0);
        check("rst_vid_rdata",   32'(bus.vid_rdata_o),   0);
        check("rst_host_rdata",  32'(bus.host_rdata_o),  0);
    endtask

    // One clock cycle: drive, check at negedge, advance model, end just after posedge.
    task automatic step(input logic blank, input logic vreq, input logic [AW-1:0] vaddr,
                        input logic hval, input logic hwe, input logic [AW-1:0] haddr,
                        input logic [DW-1:0] hwd);
        logic host_wins, vid_wins;
        ret_t r;
        bus.blank_i      = blank;
        bus.vid_req_i    = vreq;
        bus.vid_addr_i   = vaddr;
        bus.host_valid_i = hval;
        bus.host_we_i    = hwe;
        bus.host_addr_i  = haddr;
        bus.host_wdata_i = hwd;
        @(negedge clk);

        host_wins = hval && (!vreq || blank || losses >= HOST_SLOT - 1);
        vid_wins  = vreq && !host_wins;
        check("vid_ack",    32'(bus.vid_ack_o),    32'(vid_wins));
        check("host_ready", 32'(bus.host_ready_o), 32'(host_wins));
        check("mem_en",     32'(bus.mem_en_o),     32'(exp_en));
        check("mem_we",     32'(bus.mem_we_o),     32'(exp_we));
        check("mem_addr",   32'(bus.mem_addr_o),   32'(exp_addr));
        if (exp_we) check("mem_wdata", 32'(bus.mem_wdata_o), 32'(exp_wdata));
        vid_seen += int'(bus.vid_ack_o);

        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            r = exp_q.pop_front();
            check("vid_rvalid",  32'(bus.vid_rvalid_o),  32'(!r.host));
            check("host_rvalid", 32'(bus.host_rvalid_o), 32'(r.host));
            if (r.host) check("host_rdata", 32'(bus.host_rdata_o), 32'(r.data));
            else        check("vid_rdata",  32'(bus.vid_rdata_o),  32'(r.data));
        end else begin
            check("vid_rvalid_idle",  32'(bus.vid_rvalid_o),  0);
            check("host_rvalid_idle", 32'(bus.host_rvalid_o), 0);
        end

        losses = (hval && !host_wins) ? losses + 1 : 0;
        if (losses > HOST_SLOT - 1) losses = HOST_SLOT - 1;
        exp_en = host_wins || vid_wins;
        exp_we = host_wins && hwe;
        if (vid_wins) exp_addr = vaddr;
        else if (host_wins) exp_addr = haddr;
        if (vid_wins)
            exp_q.push_back('{cyc + 2 + RD_LAT, 1'b0, ref_rd(vaddr)});
        else if (host_wins && !hwe)
            exp_q.push_back('{cyc + 2 + RD_LAT, 1'b1, ref_rd(haddr)});
        if (exp_we) begin
            exp_wdata = hwd;
            ref_mem[haddr] = hwd;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        bus.blank_i      = 1'b0;
        bus.vid_req_i    = 1'b0;
        bus.vid_addr_i   = '0;
        bus.host_valid_i = 1'b0;
        bus.host_we_i    = 1'b0;
        bus.host_addr_i  = '0;
        bus.host_wdata_i = '0;

        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // Single video read of the preloaded word
        step(1'b0, 1'b1, 17'h00010, 1'b0, 1'b0, '0, '0);
        idle(6);

        // Both requesting in active video: 7 video then 1 host, repeating
        vid_seen = 0;
        for (int i = 0; i < 24; i++)
            step(1'b0, 1'b1, AW'(i), 1'b1, 1'b0, AW'(i + 100), '0);
        check("vid_share_active", 32'(vid_seen), 21);
        idle(6);

        // Both requesting during blanking: host every cycle, then video resumes
        vid_seen = 0;
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, AW'(i), 1'b1, 1'b0, AW'(i + 200), '0);
        check("vid_share_blank", 32'(vid_seen), 0);
        step(1'b0, 1'b1, 17'h00005, 1'b1, 1'b0, 17'h00300, '0);
        idle(6);

        // Host write then read-back of the same word
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 17'h00100, 16'h1234);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 17'h00100, '0);
        idle(6);

        // Interleaved video / host / video reads
        step(1'b0, 1'b1, 17'h00000, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 17'h00002, '0);
        step(1'b0, 1'b1, 17'h00001, 1'b0, 1'b0, '0, '0);
        idle(6);

        // Random traffic over a small address window to provoke read-after-write
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
                 AW'($urandom_range(0, 63)), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), DW'($urandom));
        idle(RD_LAT + 4);
        check("drain_empty", 32'(exp_q.size()), 0);

        // Reset with two reads in flight: they must vanish
        step(1'b0, 1'b1, 17'h00003, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 17'h00004, '0);
        bus.vid_req_i    = 1'b0;
        bus.host_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        exp_q.delete();
        losses    = 0;
        exp_en    = 1'b0;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc += 2;
        idle(6);
        step(1'b0, 1'b1, 17'h00010, 1'b0, 1'b0, '0, '0);
        idle(6);
        check("final_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
